// File: rtl/raystore_param.sv
`default_nettype none
// ============================================================================
//  Module   : raystore_param
//  Purpose  : Ray-vector store. A 2**ADDR_W x DATA_W memory with one
//             always-accepted write port and one pipelined, flow-controlled
//             read port. Each read carries a sideband tag that comes back
//             unchanged with the data. Reads pass through two pipeline
//             stages and then an in-order output FIFO that has fall-through
//             when empty.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             us_valid, us_sb_data,
//             raddr, us_stall        - upstream read request handshake
//             we, wdata, waddr       - write port (never stalled)
//             ds_valid, ds_sb_data,
//             ds_rd_data, ds_stall   - downstream result handshake
//  Revision : 1.0 - initial release
// ============================================================================
module raystore_param #(
    parameter int SB_WIDTH   = 8,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 192,
    parameter int FIFO_DEPTH = 4     // must be >= 3
) (
    input  logic                clk,
    input  logic                rst,
    // upstream read request
    input  logic                us_valid,
    input  logic [SB_WIDTH-1:0] us_sb_data,
    input  logic [ADDR_W-1:0]   raddr,
    output logic                us_stall,
    // write port
    input  logic                we,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   waddr,
    // downstream result
    output logic                ds_valid,
    output logic [SB_WIDTH-1:0] ds_sb_data,
    output logic [DATA_W-1:0]   ds_rd_data,
    input  logic                ds_stall
);

    localparam int c_MEM_DEPTH = 2 ** ADDR_W;
    localparam int c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int c_TOT_W     = c_CNT_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_TOT_W-1:0] c_TOT_MAX  = c_TOT_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_mem [c_MEM_DEPTH];

    // Read pipeline
    logic                r_s1_valid;
    logic [ADDR_W-1:0]   r_s1_addr;
    logic [SB_WIDTH-1:0] r_s1_tag;
    logic                r_s2_valid;
    logic [SB_WIDTH-1:0] r_s2_tag;
    logic [DATA_W-1:0]   r_s2_data;

    // Output FIFO
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [SB_WIDTH-1:0] r_fifo_tag  [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    // Handshake / control wires
    logic                w_accept;
    logic                w_fifo_empty;
    logic                w_consume;
    logic                w_push;
    logic                w_pop;
    logic [c_TOT_W-1:0]  w_total;

    // ------------------------------------------------------------------
    // Upstream flow control.
    // Every read in S1, S2 or the FIFO already owns a FIFO slot, so once
    // the sum reaches FIFO_DEPTH nothing more may enter. Because the
    // reservation is made at acceptance, the pipeline itself never has to
    // stall: S2 can always be pushed into the FIFO. The stall depends only
    // on registered state, so there is no combinational path from
    // us_valid or ds_stall.
    // ------------------------------------------------------------------
    assign w_total  = c_TOT_W'(r_count)
                    + c_TOT_W'(r_s1_valid)
                    + c_TOT_W'(r_s2_valid);
    assign us_stall = (w_total >= c_TOT_MAX);
    assign w_accept = us_valid & ~us_stall & ~rst;

    // ------------------------------------------------------------------
    // Memory write port. Writes during reset are ignored; the array
    // itself is never cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture address and tag of the accepted read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_addr <= raddr;
            r_s1_tag  <= us_sb_data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: register the memory output.
    // The array is read during the cycle after acceptance. At that point
    // a write made in the acceptance cycle is already in the array
    // (write-first collision), while a write made in this same cycle only
    // lands at its end, so it cannot disturb the captured value. This
    // gives the snapshot behaviour without a separate bypass path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_s2_tag  <= r_s1_tag;
        r_s2_data <= r_mem[r_s1_addr];
    end

    // ------------------------------------------------------------------
    // Output FIFO with fall-through.
    // When the FIFO is empty, S2 is presented directly. If that result is
    // consumed in the same cycle it never enters the FIFO. Otherwise S2
    // is pushed, and the FIFO head takes priority at the output, which
    // preserves order.
    // ------------------------------------------------------------------
    assign w_fifo_empty = (r_count == '0);
    assign ds_valid     = ~w_fifo_empty | r_s2_valid;
    assign ds_sb_data   = w_fifo_empty ? r_s2_tag  : r_fifo_tag[r_rd_ptr];
    assign ds_rd_data   = w_fifo_empty ? r_s2_data : r_fifo_data[r_rd_ptr];

    assign w_consume = ds_valid & ~ds_stall;
    assign w_pop     = w_consume & ~w_fifo_empty;
    assign w_push    = r_s2_valid & ~(w_fifo_empty & w_consume);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= r_s2_data;
            r_fifo_tag[r_wr_ptr]  <= r_s2_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            // Push and pop in the same cycle leave the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raystore_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_raystore_param
//  Purpose  : Self-checking bench for raystore_param. A transaction-level
//             model (queue of outstanding reads with their snapshot data and
//             acceptance cycle) predicts us_stall, ds_valid and the presented
//             result every cycle; directed sequences pin the model with
//             literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_raystore_param;

    localparam int SB    = 8;
    localparam int AW    = 8;
    localparam int DW    = 192;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          us_valid;
    logic [SB-1:0] us_sb_data;
    logic [AW-1:0] raddr;
    logic          us_stall;
    logic          we;
    logic [DW-1:0] wdata;
    logic [AW-1:0] waddr;
    logic          ds_valid;
    logic [SB-1:0] ds_sb_data;
    logic [DW-1:0] ds_rd_data;
    logic          ds_stall;

    raystore_param #(
        .SB_WIDTH  (SB),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .us_valid  (us_valid),
        .us_sb_data(us_sb_data),
        .raddr     (raddr),
        .us_stall  (us_stall),
        .we        (we),
        .wdata     (wdata),
        .waddr     (waddr),
        .ds_valid  (ds_valid),
        .ds_sb_data(ds_sb_data),
        .ds_rd_data(ds_rd_data),
        .ds_stall  (ds_stall)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: every accepted read is an entry holding its tag,
    // the memory contents at the end of its acceptance cycle (after that
    // cycle's write), and the cycle it was accepted in.
    // ------------------------------------------------------------------
    typedef struct {
        logic [SB-1:0] tag;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mem_m [2**AW];

    always @(negedge clk) begin
        logic exp_stall;
        logic exp_valid;
        exp_t e;
        exp_stall = (q.size() >= DEPTH);
        exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("us_stall", 256'(us_stall), 256'(exp_stall));
        chk("ds_valid", 256'(ds_valid), 256'(exp_valid));
        if (ds_valid && exp_valid) begin
            chk("ds_sb_data", 256'(ds_sb_data), 256'(q[0].tag));
            chk("ds_rd_data", 256'(ds_rd_data), 256'(q[0].data));
        end
        if (rst) begin
            q.delete();
        end else begin
            if (ds_valid && !ds_stall && q.size() > 0) void'(q.pop_front());
            if (we) mem_m[waddr] = wdata;
            if (us_valid && !exp_stall) begin
                e.tag  = us_sb_data;
                e.data = mem_m[raddr];
                e.cyc  = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        us_valid = 1'b0;
        we       = 1'b0;
        ds_stall = 1'b0;
        rst      = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int  acc;
        logic s;
        rst = 1'b1; us_valid = 1'b0; us_sb_data = '0; raddr = '0;
        we = 1'b0; wdata = '0; waddr = '0; ds_stall = 1'b0;
        step(); step();
        rst = 1'b0;
        // reset state
        chk("reset ds_valid", 256'(ds_valid), 256'(0));
        chk("reset us_stall", 256'(us_stall), 256'(0));

        // fill the whole memory so every later read has defined data
        for (int a = 0; a < 2**AW; a++) begin
            we = 1'b1; waddr = AW'(a);
            wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step();
        end
        idle(2);

        // write then read address 3, two-cycle latency
        we = 1'b1; waddr = 8'd3; wdata = {24{8'hA5}};
        step();
        we = 1'b0; us_valid = 1'b1; raddr = 8'd3; us_sb_data = 8'h11;
        step();
        us_valid = 1'b0;
        chk("lat T+1 ds_valid", 256'(ds_valid), 256'(0));
        step();
        chk("lat T+2 ds_valid", 256'(ds_valid), 256'(1));
        chk("lat T+2 data", 256'(ds_rd_data), 256'({24{8'hA5}}));
        chk("lat T+2 tag", 256'(ds_sb_data), 256'(8'h11));
        idle(4);

        // write-first collision and snapshot
        we = 1'b1; waddr = 8'd7; wdata = {24{8'h3C}};
        us_valid = 1'b1; raddr = 8'd7; us_sb_data = 8'h21;
        step();
        wdata = {24{8'hC3}}; us_sb_data = 8'h22;
        step();
        we = 1'b0; us_valid = 1'b0;
        chk("collide data", 256'(ds_rd_data), 256'({24{8'h3C}}));
        chk("collide tag", 256'(ds_sb_data), 256'(8'h21));
        step();
        chk("snapshot next data", 256'(ds_rd_data), 256'({24{8'hC3}}));
        chk("snapshot next tag", 256'(ds_sb_data), 256'(8'h22));
        idle(4);

        // fill under ds_stall: exactly DEPTH accepted, in-order release
        ds_stall = 1'b1; us_valid = 1'b1; raddr = 8'd3; acc = 0;
        for (int i = 0; i < 10; i++) begin
            s = us_stall;
            us_sb_data = SB'(acc);
            step();
            if (!s) acc++;
        end
        us_valid = 1'b0;
        chk("fill accepted", 256'(acc), 256'(DEPTH));
        chk("fill us_stall", 256'(us_stall), 256'(1));
        ds_stall = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain valid", 256'(ds_valid), 256'(1));
            chk("drain tag", 256'(ds_sb_data), 256'(i));
            step();
        end
        chk("drain empty", 256'(ds_valid), 256'(0));
        idle(2);

        // full FIFO, then continuous push/pop with no gaps
        ds_stall = 1'b1; us_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            us_sb_data = 8'h40 + SB'(i);
            step();
        end
        ds_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            us_sb_data = 8'h50 + SB'(i);
            if (i >= 8) begin
                chk("stream ds_valid", 256'(ds_valid), 256'(1));
                chk("stream us_stall", 256'(us_stall), 256'(0));
            end
            step();
        end
        idle(6);

        // reset with reads in flight and results buffered
        ds_stall = 1'b1; us_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            us_sb_data = 8'hE0 + SB'(i);
            step();
        end
        rst = 1'b1; we = 1'b1; waddr = 8'd3; wdata = {24{8'h99}};
        step();
        rst = 1'b0; we = 1'b0; us_valid = 1'b0; ds_stall = 1'b0;
        chk("post-rst ds_valid", 256'(ds_valid), 256'(0));
        chk("post-rst us_stall", 256'(us_stall), 256'(0));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post-rst quiet", 256'(ds_valid), 256'(0));
        end
        // write during reset must have been ignored
        us_valid = 1'b1; raddr = 8'd3; us_sb_data = 8'h33;
        step();
        us_valid = 1'b0;
        step();
        chk("rst write ignored", 256'(ds_rd_data), 256'({24{8'hA5}}));
        idle(4);

        // randomized traffic: complement-address reads, random stalls
        for (int i = 0; i < 700; i++) begin
            rst        = ($urandom_range(0, 249) == 0);
            we         = 1'($urandom);
            waddr      = AW'($urandom);
            wdata      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            us_valid   = ($urandom_range(0, 3) != 0);
            raddr      = 1'($urandom) ? ~waddr : AW'($urandom);
            us_sb_data = SB'($urandom);
            ds_stall   = (i < 350) ? ($urandom_range(0, 9) < 3)
                                   : ($urandom_range(0, 9) < 7);
            step();
        end
        idle(10);
        chk("all results delivered", 256'(q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
